// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : Pipeline request/response and word-memory bus bundle for the
//               MEM-stage load/store controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
   // pipeline request side
   logic        req;
   logic        is_store;
   logic [1:0]  size;
   logic        is_unsigned;
   logic [31:0] addr;
   logic [31:0] wdata;
   // pipeline response side
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   // DataMemory side
   logic        ReadMem;
   logic        WriteMem;
   logic [31:0] Addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   // the load/store controller
   modport slave (
      input  req, is_store, size, is_unsigned, addr, wdata, mem_rdata,
      output busy, done, err, rdata, ReadMem, WriteMem, Addr, mem_wdata
   );

   // pipeline plus memory, seen from outside the controller
   modport master (
      output req, is_store, size, is_unsigned, addr, wdata, mem_rdata,
      input  busy, done, err, rdata, ReadMem, WriteMem, Addr, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store controller for a word-only DataMemory.
//               Byte/half stores use read-modify-write; loads are extracted
//               (big-endian lanes) and sign/zero extended.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
   parameter int RD_LAT = 0
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   mem_access_unit_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] c_rd_last = RD_LAT[1:0];
   localparam logic [1:0] c_sz_byte = 2'b00;
   localparam logic [1:0] c_sz_half = 2'b01;
   localparam logic [1:0] c_sz_word = 2'b10;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_is_store;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [1:0]  r_off;
   logic [31:0] r_wdata;
   logic [1:0]  r_rd_cnt;
   logic        r_err;
   logic [31:0] r_rdata;
   logic [31:0] r_addr;
   logic [31:0] r_mem_wdata;

   logic        w_accept;
   logic        w_bad;
   logic        w_read_last;
   logic [7:0]  w_lane_byte;
   logic [15:0] w_lane_half;
   logic [31:0] w_load_val;
   logic [31:0] w_merged;

   assign w_accept    = (r_state == ST_IDLE) && bus.req;
   assign w_bad       = (bus.size == 2'b11) ||
                        ((bus.size == c_sz_half) && bus.addr[0]) ||
                        ((bus.size == c_sz_word) && (bus.addr[1:0] != 2'b00));
   assign w_read_last = (r_state == ST_READ) && (r_rd_cnt == c_rd_last);

   // State register; async reset so enables derived from state drop at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; word stores skip the read, errors go straight to DONE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.req) begin
               if (w_bad)                                     w_state_nxt = ST_DONE;
               else if (bus.is_store && bus.size == c_sz_word) w_state_nxt = ST_WRITE;
               else                                           w_state_nxt = ST_READ;
            end
         end
         ST_READ: begin
            if (w_read_last) w_state_nxt = r_is_store ? ST_WRITE : ST_DONE;
         end
         ST_WRITE: w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Lane extraction and load extension from the word on the memory bus
   always_comb begin
      w_lane_byte = bus.mem_rdata[31:24];
      case (r_off)
         2'd0: w_lane_byte = bus.mem_rdata[31:24];
         2'd1: w_lane_byte = bus.mem_rdata[23:16];
         2'd2: w_lane_byte = bus.mem_rdata[15:8];
         2'd3: w_lane_byte = bus.mem_rdata[7:0];
         default: w_lane_byte = bus.mem_rdata[31:24];
      endcase
      w_lane_half = r_off[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
      case (r_size)
         c_sz_byte: w_load_val = {{24{~r_unsigned & w_lane_byte[7]}}, w_lane_byte};
         c_sz_half: w_load_val = {{16{~r_unsigned & w_lane_half[15]}}, w_lane_half};
         default:   w_load_val = bus.mem_rdata;
      endcase
   end

   // Read-modify-write merge: replace only the addressed lane
   always_comb begin
      w_merged = bus.mem_rdata;
      if (r_size == c_sz_byte) begin
         case (r_off)
            2'd0: w_merged[31:24] = r_wdata[7:0];
            2'd1: w_merged[23:16] = r_wdata[7:0];
            2'd2: w_merged[15:8]  = r_wdata[7:0];
            2'd3: w_merged[7:0]   = r_wdata[7:0];
            default: w_merged = bus.mem_rdata;
         endcase
      end else if (r_size == c_sz_half) begin
         if (r_off[1]) w_merged[15:0]  = r_wdata[15:0];
         else          w_merged[31:16] = r_wdata[15:0];
      end
   end

   // Request latch, read capture, write-data and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_is_store  <= 1'b0;
         r_size      <= 2'b00;
         r_unsigned  <= 1'b0;
         r_off       <= 2'b00;
         r_wdata     <= 32'd0;
         r_rd_cnt    <= 2'd0;
         r_err       <= 1'b0;
         r_rdata     <= 32'd0;
         r_addr      <= 32'd0;
         r_mem_wdata <= 32'd0;
      end else if (w_accept) begin
         r_is_store <= bus.is_store;
         r_size     <= bus.size;
         r_unsigned <= bus.is_unsigned;
         r_off      <= bus.addr[1:0];
         r_wdata    <= bus.wdata;
         r_rd_cnt   <= 2'd0;
         r_err      <= w_bad;
         if (w_bad) begin
            r_rdata <= 32'd0;
         end else begin
            r_addr <= {bus.addr[31:2], 2'b00};
            if (bus.is_store && bus.size == c_sz_word) r_mem_wdata <= bus.wdata;
         end
      end else if (r_state == ST_READ) begin
         r_rd_cnt <= r_rd_cnt + 2'd1;
         if (w_read_last) begin
            if (r_is_store) r_mem_wdata <= w_merged;
            else            r_rdata     <= w_load_val;
         end
      end
   end

   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.done      = (r_state == ST_DONE);
   assign bus.err       = (r_state == ST_DONE) && r_err;
   assign bus.rdata     = r_rdata;
   assign bus.ReadMem   = (r_state == ST_READ);
   assign bus.WriteMem  = (r_state == ST_WRITE);
   assign bus.Addr      = r_addr;
   assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed bench for mem_access_unit with RD_LAT=0 and RD_LAT=2
//               instances sharing one stimulus stream, selected by sel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

   logic clk;
   logic rst_n;
   logic preload;
   logic sel;

   logic        req, is_store, is_unsigned;
   logic [1:0]  size;
   logic [31:0] addr, wdata;

   int n_vec = 0;
   int n_bad = 0;

   mem_access_unit_if b0 ();
   mem_access_unit_if b2 ();

   mem_access_unit #(.RD_LAT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   mem_access_unit #(.RD_LAT(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // shared request, gated to the selected instance
   assign b0.req = req & ~sel;
   assign b2.req = req & sel;
   assign b0.is_store = is_store;     assign b2.is_store = is_store;
   assign b0.size = size;             assign b2.size = size;
   assign b0.is_unsigned = is_unsigned; assign b2.is_unsigned = is_unsigned;
   assign b0.addr = addr;             assign b2.addr = addr;
   assign b0.wdata = wdata;           assign b2.wdata = wdata;

   // word memories; the latency-2 model returns garbage until the 3rd read cycle
   logic [31:0] mem0 [0:15];
   logic [31:0] mem2 [0:15];
   logic [1:0]  rc2;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) begin
            mem0[i] <= 32'd0;
            mem2[i] <= 32'd0;
         end
         mem0[4] <= 32'h8899AABB;
         mem2[4] <= 32'h8899AABB;
      end else begin
         if (b0.WriteMem) mem0[b0.Addr[5:2]] <= b0.mem_wdata;
         if (b2.WriteMem) mem2[b2.Addr[5:2]] <= b2.mem_wdata;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)          rc2 <= 2'd0;
      else if (b2.ReadMem) rc2 <= (rc2 == 2'd3) ? 2'd3 : rc2 + 2'd1;
      else                 rc2 <= 2'd0;
   end

   assign b0.mem_rdata = mem0[b0.Addr[5:2]];
   assign b2.mem_rdata = (b2.ReadMem && rc2 >= 2'd2) ? mem2[b2.Addr[5:2]] : 32'hDEAD0000;

   // observation mux
   logic        m_busy, m_done, m_err, m_rd, m_wr;
   logic [31:0] m_rdata, m_addr, m_wdat;
   assign m_busy  = sel ? b2.busy      : b0.busy;
   assign m_done  = sel ? b2.done      : b0.done;
   assign m_err   = sel ? b2.err       : b0.err;
   assign m_rd    = sel ? b2.ReadMem   : b0.ReadMem;
   assign m_wr    = sel ? b2.WriteMem  : b0.WriteMem;
   assign m_rdata = sel ? b2.rdata     : b0.rdata;
   assign m_addr  = sel ? b2.Addr      : b0.Addr;
   assign m_wdat  = sel ? b2.mem_wdata : b0.mem_wdata;

   // results of the last run_op
   int          t_lat, t_rd, t_wr;
   logic        t_err, t_done, t_addr_ok, t_overlap, t_err_leak;
   logic [31:0] t_rdata, t_wword;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request from IDLE; k counts cycles after the accept edge
   task automatic run_op(input logic s, input logic st, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
      sel = s; is_store = st; size = sz; is_unsigned = uns; addr = a; wdata = wd;
      req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      t_lat = 0; t_rd = 0; t_wr = 0; t_done = 1'b0; t_err = 1'b0;
      t_addr_ok = 1'b1; t_overlap = 1'b0; t_err_leak = 1'b0;
      t_rdata = 32'd0; t_wword = 32'd0;
      for (int k = 1; k <= 20 && !t_done; k++) begin
         if (m_rd) begin
            t_rd++;
            if (m_addr !== {a[31:2], 2'b00}) t_addr_ok = 1'b0;
         end
         if (m_wr) begin
            t_wr++;
            t_wword = m_wdat;
            if (m_addr !== {a[31:2], 2'b00}) t_addr_ok = 1'b0;
         end
         if (m_rd && m_wr) t_overlap = 1'b1;
         if (m_done) begin
            t_done = 1'b1; t_lat = k; t_err = m_err; t_rdata = m_rdata;
         end else begin
            if (m_err) t_err_leak = 1'b1;
            @(posedge clk); #1;
         end
      end
      check("timeout", {31'd0, t_done}, 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin : stim
      int          nrd, ndone, nwr;
      logic [11:0] pat;

      rst_n = 1'b0; preload = 1'b1; sel = 1'b0;
      req = 1'b0; is_store = 1'b0; size = 2'b00; is_unsigned = 1'b0;
      addr = 32'd0; wdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ctl0",  {27'd0, b0.busy, b0.done, b0.err, b0.ReadMem, b0.WriteMem}, 32'd0);
      check("rst_ctl2",  {27'd0, b2.busy, b2.done, b2.err, b2.ReadMem, b2.WriteMem}, 32'd0);
      check("rst_addr",  b0.Addr, 32'd0);
      check("rst_wdata", b0.mem_wdata, 32'd0);
      check("rst_rdata", b0.rdata, 32'd0);
      preload = 1'b0;
      rst_n   = 1'b1;
      @(posedge clk); #1;

      // ---- RD_LAT = 0 ----
      run_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h11, 32'd0);          // LB
      check("lb_rdata", t_rdata, 32'hFFFFFF99);
      check("lb_err",   {31'd0, t_err}, 32'd0);
      check("lb_lat",   t_lat, 32'd2);
      check("lb_nrd",   t_rd, 32'd1);
      check("lb_nwr",   t_wr, 32'd0);
      check("lb_addr",  {31'd0, t_addr_ok}, 32'd1);

      run_op(1'b0, 1'b0, 2'b00, 1'b1, 32'h13, 32'd0);          // LBU
      check("lbu_rdata", t_rdata, 32'h000000BB);
      run_op(1'b0, 1'b0, 2'b01, 1'b0, 32'h12, 32'd0);          // LH
      check("lh_rdata", t_rdata, 32'hFFFFAABB);
      run_op(1'b0, 1'b0, 2'b01, 1'b1, 32'h10, 32'd0);          // LHU
      check("lhu_rdata", t_rdata, 32'h00008899);
      run_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);          // LW
      check("lw_rdata", t_rdata, 32'h8899AABB);

      run_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h12, 32'h00000055);   // SB
      check("sb_wword", t_wword, 32'h889955BB);
      check("sb_lat",   t_lat, 32'd3);
      check("sb_nrd",   t_rd, 32'd1);
      check("sb_nwr",   t_wr, 32'd1);
      check("sb_ovl",   {31'd0, t_overlap}, 32'd0);
      check("sb_rdata_held", t_rdata, 32'h8899AABB);
      run_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);          // LW after SB
      check("lw2_rdata", t_rdata, 32'h889955BB);

      run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);   // SW
      check("sw_nrd", t_rd, 32'd0);
      check("sw_nwr", t_wr, 32'd1);
      check("sw_lat", t_lat, 32'd2);
      check("sw_wword", t_wword, 32'hDEADBEEF);
      check("sw_mem", mem0[8], 32'hDEADBEEF);

      run_op(1'b0, 1'b0, 2'b01, 1'b0, 32'h20, 32'd0);          // LH of stored word
      check("lh20_rdata", t_rdata, 32'hFFFFDEAD);

      run_op(1'b0, 1'b0, 2'b11, 1'b0, 32'h20, 32'd0);          // illegal size
      check("ill_err",   {31'd0, t_err}, 32'd1);
      check("ill_rdata", t_rdata, 32'd0);
      check("ill_en",    t_rd + t_wr, 32'd0);

      run_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);          // reload rdata
      run_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h21, 32'h1234);       // misaligned SH
      check("sh_err",   {31'd0, t_err}, 32'd1);
      check("sh_rdata", t_rdata, 32'd0);
      check("sh_en",    t_rd + t_wr, 32'd0);
      check("sh_lat",   t_lat, 32'd1);
      check("sh_mem",   mem0[8], 32'hDEADBEEF);
      check("sh_leak",  {31'd0, t_err_leak}, 32'd0);

      // ---- RD_LAT = 2 ----
      run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);          // LW
      check("l2_lw_rdata", t_rdata, 32'h8899AABB);
      check("l2_lw_lat",   t_lat, 32'd4);
      check("l2_lw_nrd",   t_rd, 32'd3);
      check("l2_lw_addr",  {31'd0, t_addr_ok}, 32'd1);
      run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'd0);          // LB
      check("l2_lb_rdata", t_rdata, 32'hFFFFFF99);
      check("l2_lb_lat",   t_lat, 32'd4);
      run_op(1'b1, 1'b1, 2'b00, 1'b0, 32'h13, 32'h00000077);   // SB
      check("l2_sb_wword", t_wword, 32'h8899AA77);
      check("l2_sb_lat",   t_lat, 32'd5);
      check("l2_sb_nrd",   t_rd, 32'd3);
      check("l2_sb_nwr",   t_wr, 32'd1);
      check("l2_sb_addr",  {31'd0, t_addr_ok}, 32'd1);
      run_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'd0);          // LHU
      check("l2_lhu_rdata", t_rdata, 32'h0000AA77);
      run_op(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);   // SW
      check("l2_sw_lat", t_lat, 32'd2);
      check("l2_sw_nrd", t_rd, 32'd0);

      // ---- req held high: accepts only from IDLE (3-cycle period for LW) ----
      sel = 1'b0; is_store = 1'b0; size = 2'b10; is_unsigned = 1'b0;
      addr = 32'h10; req = 1'b1;
      @(posedge clk); #1;
      nrd = 0; ndone = 0; pat = 12'd0;
      for (int k = 1; k <= 12; k++) begin
         pat[k-1] = m_busy;
         if (m_rd)   nrd++;
         if (m_done) ndone++;
         @(posedge clk); #1;
      end
      req = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      check("hold_busy_pat", {20'd0, pat}, 32'h6DB);
      check("hold_nrd",   nrd, 32'd4);
      check("hold_ndone", ndone, 32'd4);

      // ---- reset in the middle of an SB read (RD_LAT = 2) ----
      sel = 1'b1; is_store = 1'b1; size = 2'b00; addr = 32'h10; wdata = 32'h000000CC;
      req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      check("abort_pre_rd", {31'd0, b2.ReadMem}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_rd",   {31'd0, b2.ReadMem}, 32'd0);
      check("abort_busy", {31'd0, b2.busy}, 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      nwr = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (b2.WriteMem || b2.ReadMem) nwr++;
      end
      check("abort_no_access", nwr, 32'd0);
      check("abort_mem", mem2[4], 32'h8899AA77);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store controller for the MIPS MEM stage.
- Accepts one byte/halfword/word load or store request at a time from the pipeline and drives the word-only DataMemory interface (ReadMem, WriteMem, Addr, write data, read data).
- Sub-word stores are done as read-modify-write; loads are extracted and sign- or zero-extended.
- Reports completion with a one-cycle done pulse and flags misaligned or illegal requests.

Parameters:
- RD_LAT, 0, memory read latency in cycles from ReadMem assertion to valid mem_rdata. Legal range 0-3; 0 means combinational read.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  request strobe; sampled only in IDLE.
- is_store  input  1  1 = store, 0 = load.
- size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- is_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- addr  input  32  byte address.
- wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done: misaligned or illegal size.
- rdata  output  32  load result; valid with done, held until next accept.
- ReadMem  output  1  memory read enable.
- WriteMem  output  1  memory write enable; memory writes on the clk edge ending this cycle.
- Addr  output  32  word address to memory, {addr[31:2],2'b00}.
- mem_wdata  output  32  write data to memory (connects to DataMemory Data_i).
- mem_rdata  input  32  read data from memory (connects to DataMemory Data).

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, err, ReadMem, WriteMem = 0; Addr, mem_wdata, rdata = 0. Memory enables drop immediately, not at the next edge.
- Reset mid-operation aborts the access; no partial write is issued afterwards.
- Byte order is big-endian: byte offset 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0]. Half offset 0 = [31:16], 2 = [15:0].
- Accept: in IDLE with req=1, latch is_store/size/is_unsigned/addr/wdata.
- req is ignored while busy=1, including in the DONE cycle.
- States: IDLE, READ, WRITE, DONE.
- Error check at accept, giving err=1:
  - size=11;
  - size=01 with addr[0]=1;
  - size=10 with addr[1:0]!=0.
- On error: go IDLE->DONE; no ReadMem or WriteMem ever asserted; rdata=0.
- Load: IDLE->READ.
  - READ holds ReadMem=1 and Addr stable for RD_LAT+1 cycles; mem_rdata is captured on the last READ cycle.
  - Then DONE: done=1, rdata = extracted lane, extended per is_unsigned.
  - done occurs RD_LAT+2 cycles after the accept edge.
- SW: IDLE->WRITE.
  - WRITE asserts WriteMem=1 for one cycle with mem_wdata=wdata.
  - Then DONE; done occurs 2 cycles after accept.
- SB/SH: IDLE->READ (as for load) -> WRITE -> DONE.
  - In WRITE, mem_wdata = captured word with the addressed lane replaced by wdata[7:0] or wdata[15:0]; other lanes unchanged.
  - done occurs RD_LAT+3 cycles after accept.
- ReadMem and WriteMem are never high in the same cycle.
- Outside READ/WRITE both enables are 0; Addr holds its last value.
- DONE lasts exactly one cycle, then IDLE.
- err is 0 whenever done=0.
- rdata is unchanged by stores, and holds its last value until the next load or error completes.

Test Plan:
- Preload word 0x10 = 0x8899AABB, RD_LAT=0. LB 0x11 -> ReadMem one cycle, Addr=0x10; done 2 cycles after accept; rdata=0xFFFFFF99, err=0.
- LBU 0x13 -> 0x000000BB. LH 0x12 -> 0xFFFFAABB. LHU 0x10 -> 0x00008899. LW 0x10 -> 0x8899AABB.
- SB 0x12, wdata=0x00000055 -> one read then one WriteMem with mem_wdata=0x889955BB; later LW 0x10 returns 0x889955BB; done RD_LAT+3 cycles after accept.
- SW 0x20, wdata=0xDEADBEEF -> no ReadMem, WriteMem one cycle, done 2 cycles after accept. SH 0x21 or size=11 -> done with err=1, rdata=0, no memory enables.
- Rerun the load/store cases with RD_LAT=2 -> ReadMem held 3 cycles, Addr stable throughout; LW done 4 cycles after accept, SB done 5 cycles after accept.
- Hold req=1 continuously -> a new request is accepted only in IDLE, never in READ/WRITE/DONE.
- Assert rst_n=0 during READ of an SB -> ReadMem drops immediately, no WriteMem follows, busy=0; memory word unchanged.
